// File: rtl/mod_alu_pipe.sv
// Pipelined modular ALU: operands are registered, the product is reduced mod q by a
// RED_LAT-stage shift/subtract reducer, then the final stage adds/subtracts and owns acc.
// Optional macro MOD_ALU_PIPE_STATS_EN enables the op_count operation counter.
module mod_alu_pipe #(
   parameter int D_WIDTH = 32,
   parameter int RED_LAT = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         opcode,
   input  logic [D_WIDTH-1:0] in_a,
   input  logic [D_WIDTH-1:0] in_b,
   input  logic [D_WIDTH-1:0] in_w,
   input  logic [D_WIDTH-1:0] in_q,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [D_WIDTH-1:0] out0,
   output logic [D_WIDTH-1:0] out1,
   output logic               illegal,
   output logic [31:0]        op_count
);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_MAC  = 4'd4;
   localparam logic [3:0] OP_BFU  = 4'd5;
   localparam logic [3:0] OP_IBFU = 4'd6;
   localparam logic [3:0] OP_ACLR = 4'd7;

   // Product bits consumed per reducer stage; the product is zero-padded to PW bits.
   localparam int BPS = (2*D_WIDTH + RED_LAT - 1) / RED_LAT;
   localparam int PW  = BPS * RED_LAT;

   function automatic logic [D_WIDTH-1:0] f_add_mod(input logic [D_WIDTH-1:0] x,
                                                    input logic [D_WIDTH-1:0] y,
                                                    input logic [D_WIDTH-1:0] q);
      logic [D_WIDTH:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, q})
         s = s - {1'b0, q};
      return s[D_WIDTH-1:0];
   endfunction

   function automatic logic [D_WIDTH-1:0] f_sub_mod(input logic [D_WIDTH-1:0] x,
                                                    input logic [D_WIDTH-1:0] y,
                                                    input logic [D_WIDTH-1:0] q);
      return (x >= y) ? (x - y) : (x - y + q);
   endfunction

   // Remainder stays below q < 2^(D_WIDTH-1), so shifting in one bit never overflows.
   function automatic logic [D_WIDTH-1:0] f_mod_step(input logic [D_WIDTH-1:0] rem,
                                                     input logic [PW-1:0]      prod,
                                                     input logic [D_WIDTH-1:0] q);
      logic [D_WIDTH-1:0] r;
      r = rem;
      for (int i = 0; i < BPS; i++) begin
         r = {r[D_WIDTH-2:0], prod[PW-1-i]};
         if (r >= q)
            r = r - q;
      end
      return r;
   endfunction

   logic                 w_stall;
   logic                 w_accept;

   logic                 r_s1_vld;
   logic [3:0]           r_s1_op;
   logic [D_WIDTH-1:0]   r_s1_a, r_s1_b, r_s1_w, r_s1_q;

   logic [D_WIDTH-1:0]   w_mx, w_my;
   logic [2*D_WIDTH-1:0] w_prod_full;
   logic [PW-1:0]        w_prod_pad;

   logic                 w_in_vld  [RED_LAT];
   logic [3:0]           w_in_op   [RED_LAT];
   logic [D_WIDTH-1:0]   w_in_a    [RED_LAT];
   logic [D_WIDTH-1:0]   w_in_b    [RED_LAT];
   logic [D_WIDTH-1:0]   w_in_q    [RED_LAT];
   logic [D_WIDTH-1:0]   w_in_rem  [RED_LAT];
   logic [PW-1:0]        w_in_prod [RED_LAT];

   logic                 r_rd_vld  [RED_LAT];
   logic [3:0]           r_rd_op   [RED_LAT];
   logic [D_WIDTH-1:0]   r_rd_a    [RED_LAT];
   logic [D_WIDTH-1:0]   r_rd_b    [RED_LAT];
   logic [D_WIDTH-1:0]   r_rd_q    [RED_LAT];
   logic [D_WIDTH-1:0]   r_rd_rem  [RED_LAT];
   logic [PW-1:0]        r_rd_prod [RED_LAT];

   logic                 w_fin_vld;
   logic [3:0]           w_fin_op;
   logic [D_WIDTH-1:0]   w_fin_a, w_fin_b, w_fin_q, w_fin_m;
   logic [D_WIDTH-1:0]   w_fin0, w_fin1, w_fin_acc;

   logic                 r_out_vld;
   logic [D_WIDTH-1:0]   r_out0, r_out1, r_acc;
   logic                 r_illegal;

   assign w_stall   = r_out_vld && !out_ready;
   assign in_ready  = !w_stall || !rst_n;
   assign w_accept  = in_valid && !w_stall;
   assign out_valid = r_out_vld;
   assign out0      = r_out0;
   assign out1      = r_out1;
   assign illegal   = r_illegal;

   // IBFU reduces the difference before multiplying by the twiddle.
   always_comb begin
      w_mx = r_s1_a;
      w_my = r_s1_b;
      case (r_s1_op)
         OP_BFU: begin
            w_mx = r_s1_b;
            w_my = r_s1_w;
         end
         OP_IBFU: begin
            w_mx = f_sub_mod(r_s1_a, r_s1_b, r_s1_q);
            w_my = r_s1_w;
         end
         default: ;
      endcase
   end

   assign w_prod_full = {{D_WIDTH{1'b0}}, w_mx} * {{D_WIDTH{1'b0}}, w_my};
   assign w_prod_pad  = PW'(w_prod_full);

   always_comb begin
      w_in_vld[0]  = r_s1_vld;
      w_in_op[0]   = r_s1_op;
      w_in_a[0]    = r_s1_a;
      w_in_b[0]    = r_s1_b;
      w_in_q[0]    = r_s1_q;
      w_in_rem[0]  = '0;
      w_in_prod[0] = w_prod_pad;
      for (int s = 1; s < RED_LAT; s++) begin
         w_in_vld[s]  = r_rd_vld[s-1];
         w_in_op[s]   = r_rd_op[s-1];
         w_in_a[s]    = r_rd_a[s-1];
         w_in_b[s]    = r_rd_b[s-1];
         w_in_q[s]    = r_rd_q[s-1];
         w_in_rem[s]  = r_rd_rem[s-1];
         w_in_prod[s] = r_rd_prod[s-1];
      end
   end

   assign w_fin_vld = r_rd_vld[RED_LAT-1];
   assign w_fin_op  = r_rd_op[RED_LAT-1];
   assign w_fin_a   = r_rd_a[RED_LAT-1];
   assign w_fin_b   = r_rd_b[RED_LAT-1];
   assign w_fin_q   = r_rd_q[RED_LAT-1];
   assign w_fin_m   = r_rd_rem[RED_LAT-1];

   always_comb begin
      w_fin0    = '0;
      w_fin1    = r_out1;
      w_fin_acc = r_acc;
      case (w_fin_op)
         OP_ADD: w_fin0 = f_add_mod(w_fin_a, w_fin_b, w_fin_q);
         OP_SUB: w_fin0 = f_sub_mod(w_fin_a, w_fin_b, w_fin_q);
         OP_MUL: w_fin0 = w_fin_m;
         OP_MAC: begin
            w_fin_acc = f_add_mod(r_acc, w_fin_m, w_fin_q);
            w_fin0    = w_fin_acc;
         end
         OP_BFU: begin
            w_fin0 = f_add_mod(w_fin_a, w_fin_m, w_fin_q);
            w_fin1 = f_sub_mod(w_fin_a, w_fin_m, w_fin_q);
         end
         OP_IBFU: begin
            w_fin0 = f_add_mod(w_fin_a, w_fin_b, w_fin_q);
            w_fin1 = w_fin_m;
         end
         OP_ACLR: begin
            w_fin_acc = '0;
            w_fin0    = '0;
         end
         default: ;
      endcase
   end

   // Control and architectural state; NOP and illegal opcodes enter as bubbles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         for (int s = 0; s < RED_LAT; s++)
            r_rd_vld[s] <= 1'b0;
         r_out_vld <= 1'b0;
         r_out0    <= '0;
         r_out1    <= '0;
         r_acc     <= '0;
         r_illegal <= 1'b0;
      end else if (!w_stall) begin
         r_s1_vld <= w_accept && (opcode != OP_NOP) && !opcode[3];
         if (w_accept && opcode[3])
            r_illegal <= 1'b1;
         for (int s = 0; s < RED_LAT; s++)
            r_rd_vld[s] <= w_in_vld[s];
         r_out_vld <= w_fin_vld;
         if (w_fin_vld) begin
            r_out0 <= w_fin0;
            r_out1 <= w_fin1;
            r_acc  <= w_fin_acc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!w_stall) begin
         r_s1_op <= opcode;
         r_s1_a  <= in_a;
         r_s1_b  <= in_b;
         r_s1_w  <= in_w;
         r_s1_q  <= in_q;
         for (int s = 0; s < RED_LAT; s++) begin
            r_rd_op[s]   <= w_in_op[s];
            r_rd_a[s]    <= w_in_a[s];
            r_rd_b[s]    <= w_in_b[s];
            r_rd_q[s]    <= w_in_q[s];
            r_rd_rem[s]  <= f_mod_step(w_in_rem[s], w_in_prod[s], w_in_q[s]);
            r_rd_prod[s] <= w_in_prod[s] << BPS;
         end
      end
   end

`ifdef MOD_ALU_PIPE_STATS_EN
   logic [31:0] r_op_count;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_op_count <= '0;
      else if (w_accept && (opcode != OP_NOP))
         r_op_count <= r_op_count + 32'd1;
   end

   assign op_count = r_op_count;
`else
   assign op_count = '0;
`endif

endmodule

// File: tb/tb_mod_alu_pipe.sv
// Directed bench for mod_alu_pipe: hand-computed vectors, latency, MAC ordering,
// backpressure, reset with work in flight and illegal opcodes.
module tb_mod_alu_pipe;

   localparam int DW  = 32;
   localparam int RL  = 3;
   localparam int LAT = RL + 2;
   localparam logic [31:0] QBIG = 32'h7FFF_FFFF;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    opcode;
   logic [DW-1:0] in_a, in_b, in_w, in_q;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out0, out1;
   logic          illegal;
   logic [31:0]   op_count;

   int            n_pass  = 0;
   int            n_total = 0;
   logic [31:0]   exp_cnt = 0;
   int            mac_exp [4] = '{0, 12, 8, 12};

   mod_alu_pipe #(.D_WIDTH(DW), .RED_LAT(RL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_w      (in_w),
      .in_q      (in_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out0      (out0),
      .out1      (out1),
      .illegal   (illegal),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_cnt(input string tag);
`ifdef MOD_ALU_PIPE_STATS_EN
      chk(tag, op_count, exp_cnt);
`else
      chk(tag, op_count, 32'd0);
`endif
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] w, input logic [31:0] q);
      in_valid = 1'b1;
      opcode   = op;
      in_a     = a;
      in_b     = b;
      in_w     = w;
      in_q     = q;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      opcode   = 4'd0;
   endtask

   // Issue one op and return the number of rising edges until out_valid (40 = timeout).
   task automatic issue1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] w, input logic [31:0] q, output int lat);
      drive(op, a, b, w, q);
      if (in_ready && op != 4'd0) exp_cnt++;
      cyc();
      idle();
      lat = 1;
      while (!out_valid && lat < 40) begin
         cyc();
         lat++;
      end
   endtask

   initial begin
      int lat;
      int sent;
      int rcv;
      int nstall;
      int nv;

      rst_n = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; opcode = 4'd0;
      in_a = '0; in_b = '0; in_w = '0; in_q = '0;
      repeat (3) cyc();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out0", out0, 32'd0);
      chk("rst_out1", out1, 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk_cnt("rst_op_count");
      rst_n = 1'b1;
      cyc();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      issue1(4'd1, 32'd16, 32'd5, 32'd0, 32'd17, lat);
      chk("add_lat", 32'(lat), 32'(LAT));
      chk("add_out0", out0, 32'd4);
      chk("add_out1_hold", out1, 32'd0);
      cyc();
      chk("add_single_pulse", 32'(out_valid), 32'd0);

      issue1(4'd2, 32'd3, 32'd9, 32'd0, 32'd17, lat);
      chk("sub_lat", 32'(lat), 32'(LAT));
      chk("sub_out0", out0, 32'd11);
      cyc();

      issue1(4'd5, 32'd3, 32'd5, 32'd4, 32'd17, lat);
      chk("bfu_lat", 32'(lat), 32'(LAT));
      chk("bfu_out0", out0, 32'd6);
      chk("bfu_out1", out1, 32'd0);
      cyc();

      issue1(4'd6, 32'd3, 32'd5, 32'd4, 32'd17, lat);
      chk("ibfu_lat", 32'(lat), 32'(LAT));
      chk("ibfu_out0", out0, 32'd8);
      chk("ibfu_out1", out1, 32'd9);
      cyc();

      issue1(4'd3, 32'd16, 32'd16, 32'd0, 32'd17, lat);
      chk("mul_lat", 32'(lat), 32'(LAT));
      chk("mul_out0", out0, 32'd1);
      chk("mul_out1_hold", out1, 32'd9);
      cyc();

      issue1(4'd3, QBIG - 32'd1, QBIG - 32'd1, 32'd0, QBIG, lat);
      chk("mulbig_out0", out0, 32'd1);
      cyc();
      issue1(4'd1, QBIG - 32'd1, QBIG - 32'd2, 32'd0, QBIG, lat);
      chk("addbig_out0", out0, QBIG - 32'd3);
      cyc();
      issue1(4'd2, 32'd5, QBIG - 32'd1, 32'd0, QBIG, lat);
      chk("subbig_out0", out0, 32'd6);
      cyc();

      drive(4'd7, 32'd0, 32'd0, 32'd0, 32'd17); exp_cnt++; cyc();
      drive(4'd4, 32'd3, 32'd4, 32'd0, 32'd17); exp_cnt++; cyc();
      drive(4'd4, 32'd5, 32'd6, 32'd0, 32'd17); exp_cnt++; cyc();
      drive(4'd4, 32'd2, 32'd2, 32'd0, 32'd17); exp_cnt++; cyc();
      idle();
      lat = 0;
      while (!out_valid && lat < 40) begin
         cyc();
         lat++;
      end
      for (int k = 0; k < 4; k++) begin
         chk("mac_valid", 32'(out_valid), 32'd1);
         chk("mac_out0", out0, 32'(mac_exp[k]));
         cyc();
      end
      chk_cnt("mac_op_count");

      sent = 0; rcv = 0; nstall = 0;
      for (int c = 0; c < 40; c++) begin
         out_ready = !(c >= 5 && c <= 9);
         if (sent < 6) drive(4'd1, 32'(10 + sent), 32'(sent), 32'd0, 32'd17);
         else idle();
         #1;
         if (out_valid && !out_ready) begin
            nstall++;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            if (rcv < 6) chk("bp_hold_out0", out0, 32'((2 * rcv + 10) % 17));
         end
         if (out_valid && out_ready) begin
            if (rcv < 6) chk("bp_order", out0, 32'((2 * rcv + 10) % 17));
            rcv++;
         end
         if (in_valid && in_ready) begin
            sent++;
            exp_cnt++;
         end
         @(posedge clk);
         #1;
      end
      idle();
      out_ready = 1'b1;
      chk("bp_stall_cycles", 32'(nstall), 32'd5);
      chk("bp_received", 32'(rcv), 32'd6);
      chk("bp_sent", 32'(sent), 32'd6);
      chk_cnt("bp_op_count");

      chk("pre_ill_flag", 32'(illegal), 32'd0);
      drive(4'd0, 32'd1, 32'd1, 32'd0, 32'd17); cyc();
      drive(4'd9, 32'd1, 32'd1, 32'd0, 32'd17); exp_cnt++; cyc();
      idle();
      nv = 0;
      repeat (LAT + 3) begin
         if (out_valid) nv++;
         cyc();
      end
      chk("ill_no_valid", 32'(nv), 32'd0);
      chk("ill_flag", 32'(illegal), 32'd1);
      chk_cnt("ill_op_count");

      drive(4'd4, 32'd1, 32'd1, 32'd0, 32'd17); cyc();
      drive(4'd4, 32'd1, 32'd1, 32'd0, 32'd17); cyc();
      drive(4'd4, 32'd1, 32'd1, 32'd0, 32'd17); cyc();
      idle();
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      cyc();
      rst_n = 1'b1;
      exp_cnt = 0;
      chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
      nv = 0;
      repeat (LAT + 3) begin
         if (out_valid) nv++;
         cyc();
      end
      chk("midrst_no_valid", 32'(nv), 32'd0);
      chk("midrst_illegal", 32'(illegal), 32'd0);
      chk("midrst_out0", out0, 32'd0);
      chk_cnt("midrst_op_count");
      issue1(4'd4, 32'd1, 32'd1, 32'd0, 32'd17, lat);
      chk("midrst_acc_zero", out0, 32'd1);
      cyc();
      chk_cnt("final_op_count");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
